// File: rtl/reg_transfer_unit.sv
// Four-entry register bank with LOAD/MOVE/ADD/CLR command FSM; 3 cycles per command (accept, exec, done), cmd_ready only in IDLE, commands are not queued.
// Optional carry output for ADD enabled by defining REG_TRANSFER_CARRY_EN.
module reg_transfer_unit #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       mux_select,
  input  logic [WIDTH-1:0] mux_in,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
`ifdef REG_TRANSFER_CARRY_EN
  output logic             carry,
`endif
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_MOVE, OP_ADD, OP_CLR} op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [1:0]       rd_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] add_res;
  logic             accept;

  assign accept = cmd_valid && cmd_ready;

`ifdef REG_TRANSFER_CARRY_EN
  logic [WIDTH:0] sum_full;
  assign sum_full = {1'b0, regs[rd_q]} + {1'b0, mux_in};
  assign add_res  = sum_full[WIDTH-1:0];
`else
  assign add_res = regs[rd_q] + mux_in;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while resetn is asserted, even if state still reads IDLE/DONE.
  always_comb begin
    cmd_ready = resetn && (state == IDLE);
    done      = resetn && (state == DONE);
  end

  // Write-back happens on the EXEC->DONE edge; mux_in is driven from mux_select latched at accept.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) regs[i] <= RESET_VAL;
      mux_select <= 2'b00;
      op_q       <= OP_LOAD;
      rd_q       <= 2'b00;
      data_q     <= '0;
`ifdef REG_TRANSFER_CARRY_EN
      carry      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q       <= op_t'(cmd_op);
        rd_q       <= cmd_rd;
        data_q     <= cmd_data;
        mux_select <= cmd_rs;
      end
      if (state == EXEC) begin
        case (op_q)
          OP_LOAD: regs[rd_q] <= data_q;
          OP_MOVE: regs[rd_q] <= mux_in;
          OP_ADD: begin
            regs[rd_q] <= add_res;
`ifdef REG_TRANSFER_CARRY_EN
            carry      <= sum_full[WIDTH];
`endif
          end
          OP_CLR:  regs[rd_q] <= '0;
          default: regs[rd_q] <= regs[rd_q];
        endcase
      end
    end
  end

  assign reg0 = regs[0];
  assign reg1 = regs[1];
  assign reg2 = regs[2];
  assign reg3 = regs[3];

endmodule

// File: tb/tb_reg_transfer_unit.sv
// Directed bench for reg_transfer_unit; the bench models the external 4-to-1 operand mux.
module tb_reg_transfer_unit;

  logic        clock;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op, cmd_rd, cmd_rs;
  logic [15:0] cmd_data;
  logic [1:0]  mux_select;
  logic [15:0] mux_in;
  logic [15:0] reg0, reg1, reg2, reg3;
  logic        done;
`ifdef REG_TRANSFER_CARRY_EN
  logic        carry;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int done_base;

  reg_transfer_unit #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs     (cmd_rs),
    .cmd_data   (cmd_data),
    .mux_select (mux_select),
    .mux_in     (mux_in),
    .reg0       (reg0),
    .reg1       (reg1),
    .reg2       (reg2),
    .reg3       (reg3),
`ifdef REG_TRANSFER_CARRY_EN
    .carry      (carry),
`endif
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    case (mux_select)
      2'd0:    mux_in = reg0;
      2'd1:    mux_in = reg1;
      2'd2:    mux_in = reg2;
      default: mux_in = reg3;
    endcase
  end

  always @(negedge clock) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] reg_at(input logic [1:0] i);
    case (i)
      2'd0:    return reg0;
      2'd1:    return reg1;
      2'd2:    return reg2;
      default: return reg3;
    endcase
  endfunction

  // Full command: handshake, EXEC checks, DONE checks against exp, return to IDLE.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] rs, input logic [15:0] data, input logic [15:0] exp);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
    #1;
    check({tag, "_exec_ready"}, cmd_ready, 0);
    check({tag, "_exec_sel"}, mux_select, rs);
    check({tag, "_exec_done"}, done, 0);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_rd"}, reg_at(rd), exp);
    tick();
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_ready"}, cmd_ready, 1);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b1; cmd_op = 2'(3'($urandom_range(0, 3)));
    cmd_rd = 2'd1; cmd_rs = 2'd2; cmd_data = 16'hDEAD;
    tick();
    tick();
    check("rst_reg0", reg0, 16'h0000);
    check("rst_reg1", reg1, 16'h0000);
    check("rst_reg2", reg2, 16'h0000);
    check("rst_reg3", reg3, 16'h0000);
    check("rst_sel", mux_select, 2'b00);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 0);
    cmd_valid = 1'b0; resetn = 1'b1;
    #1;
    check("rel_ready", cmd_ready, 1);

    // LOAD r2 = 1234
    do_cmd("load", 2'b00, 2'd2, 2'd0, 16'h1234, 16'h1234);
    check("load_r0", reg0, 16'h0000);
    check("load_r1", reg1, 16'h0000);
    check("load_r3", reg3, 16'h0000);

    // MOVE r0 <- r2
    do_cmd("move", 2'b01, 2'd0, 2'd2, 16'h0000, 16'h1234);
    check("move_r2", reg2, 16'h1234);
    do_cmd("move_alias", 2'b01, 2'd2, 2'd2, 16'hFFFF, 16'h1234);

    // ADD overflow then ADD alias doubling
    do_cmd("load_r1", 2'b00, 2'd1, 2'd0, 16'hFFFF, 16'hFFFF);
    do_cmd("load_r3", 2'b00, 2'd3, 2'd0, 16'h0001, 16'h0001);
    do_cmd("add_ovf", 2'b10, 2'd1, 2'd3, 16'h0000, 16'h0000);
    check("add_ovf_r3", reg3, 16'h0001);
`ifdef REG_TRANSFER_CARRY_EN
    check("add_ovf_carry", carry, 1);
`endif
    do_cmd("add_alias", 2'b10, 2'd3, 2'd3, 16'h0000, 16'h0002);
`ifdef REG_TRANSFER_CARRY_EN
    check("add_alias_carry", carry, 0);
`endif
    do_cmd("clr", 2'b11, 2'd2, 2'd0, 16'hABCD, 16'h0000);
    check("clr_r0", reg0, 16'h1234);
    check("clr_r3", reg3, 16'h0002);

    // Back-to-back with cmd_valid held high
    done_base = done_cnt;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 2'd0; cmd_rs = 2'd1; cmd_data = 16'hAAAA;
    tick();
    cmd_data = 16'h5555;
    #1;
    check("b2b_exec1_ready", cmd_ready, 0);
    tick();
    check("b2b_done1", done, 1);
    check("b2b_r0_first", reg0, 16'hAAAA);
    tick();
    check("b2b_idle_r0", reg0, 16'hAAAA);
    check("b2b_idle_ready", cmd_ready, 1);
    tick();
    check("b2b_exec2_ready", cmd_ready, 0);
    check("b2b_exec2_done", done, 0);
    cmd_valid = 1'b0;
    tick();
    check("b2b_done2", done, 1);
    check("b2b_r0_final", reg0, 16'h5555);
    tick();
    check("b2b_pulses", done_cnt - done_base, 2);

    // Reset during EXEC aborts the write and the done pulse
    done_base = done_cnt;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 2'd1; cmd_rs = 2'd0; cmd_data = 16'hBEEF;
    tick();
    cmd_valid = 1'b0; resetn = 1'b0;
    tick();
    check("abort_r1", reg1, 16'h0000);
    check("abort_r0", reg0, 16'h0000);
    check("abort_done", done, 0);
    resetn = 1'b1;
    #1;
    check("abort_ready", cmd_ready, 1);
    tick();
    check("abort_r1_after", reg1, 16'h0000);
    check("abort_ready_after", cmd_ready, 1);
    check("abort_pulses", done_cnt - done_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_transfer_unit.md
Name: reg_transfer_unit

Overview:
- Four-entry 16-bit register bank plus a small command FSM.
- Registers drive the 16-bit 4-to-1 operand mux inputs (reg0..reg3 -> ins0..ins3).
- The block drives the mux select and captures the mux output back for MOVE/ADD write-back.
- Sits between the control sequencer (command source) and the operand mux; it is both the mux's upstream feeder and its downstream consumer.

Parameters:
- WIDTH, 16, data width; must match the operand mux (16).
- RESET_VAL, 16'h0000, value of every register after reset.

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- resetn  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd_op  input  2  00 LOAD, 01 MOVE, 10 ADD, 11 CLR
- cmd_rd  input  2  destination register index
- cmd_rs  input  2  source register index (MOVE/ADD)
- cmd_data  input  WIDTH  immediate for LOAD
- mux_select  output  2  to operand mux select
- mux_in  input  WIDTH  from operand mux output
- reg0, reg1, reg2, reg3  output  WIDTH  register contents to mux ins0..ins3
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (resetn=0 at edge): reg0..reg3=RESET_VAL, state=IDLE, mux_select=00, done=0, cmd_ready=0 during the reset cycle. Reset has priority over everything and aborts any in-flight command without a write or done.
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. Handshake when cmd_valid && cmd_ready at edge T0:
  - Latch op, rd, rs and data.
  - Set mux_select=cmd_rs.
  - Go to EXEC.
- cmd_valid while not in IDLE is ignored; commands are not queued.
- EXEC (cycle T0..T1): cmd_ready=0; mux_select=latched rs; mux_in is combinationally valid. At edge T1, write Rd:
  - LOAD: Rd <= latched data.
  - MOVE: Rd <= mux_in.
  - ADD: Rd <= Rd + mux_in, modulo 2^16; carry discarded.
  - CLR: Rd <= 16'h0000.
  - Go to DONE.
- DONE (cycle T1..T2): done=1, cmd_ready=0, new register value visible on regN. At edge T2 go to IDLE.
- Throughput: one command per 3 cycles; back-to-back valid is accepted at T2+ (first IDLE cycle).
- Source and destination may alias:
  - MOVE rd==rs leaves the value unchanged.
  - ADD rd==rs doubles Rd.
- The mux_in value used is the one sampled at T1; the register was not written in EXEC, so no hazard.
- mux_select holds its last value in IDLE and DONE.
- Only Rd changes on a write; the other registers hold.
- done is never asserted outside DONE.

Optional Feature:
- Macro: REG_TRANSFER_CARRY_EN.
- Defined:
  - Adds output port carry (1 bit).
  - Reset to 0.
  - On ADD write at T1, carry <= bit 16 of the 17-bit sum.
  - LOAD, MOVE and CLR leave it unchanged.
- Undefined: no carry port, no carry flop; ADD behaviour otherwise identical.

Test Plan:
- Reset: hold resetn=0 two cycles after random commands -> all regN=0000, mux_select=00, done=0; cmd_ready=1 the first cycle after release.
- LOAD: op=00, rd=2, data=16'h1234 accepted at T0 -> reg2=1234 and done=1 in cycle after T1; reg0/1/3 unchanged; cmd_ready=1 after T2.
- MOVE: preload r2=1234, then op=01, rd=0, rs=2 -> mux_select=10 during EXEC, reg0=1234 after T1, reg2 still 1234.
- ADD overflow: r1=FFFF, r3=0001, op=10, rd=1, rs=3 -> reg1=0000 (carry=1 when REG_TRANSFER_CARRY_EN). Then ADD rd=rs=3 -> reg3=0002.
- Busy/back-to-back: cmd_valid held high with LOAD r0=AAAA then LOAD r0=5555 -> second accepted exactly 3 cycles after first, final reg0=5555, two done pulses; valid during EXEC/DONE not consumed.
- Reset mid-op: accept LOAD r1=BEEF, assert resetn=0 in EXEC -> reg1=0000, no done pulse, state IDLE after release.
